// File: rtl/ex_advint_s2.sv
`default_nettype none
// ============================================================================
// Module   : ex_advint_s2
// Brief    : Advanced Integer Unit stage 2. Registers the lo/hi halves of a
//            stage-1 MUL/DIV result and writes them back as up to two beats
//            (lo first, then hi) over a single register-file write port.
//            Publishes pending destination tags for the issue scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module ex_advint_s2 #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_lo,
  input  logic [DATA_W-1:0] in_hi,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [REG_W-1:0]  in_rd2,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_W-1:0]  wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              pend_valid,
  output logic [REG_W-1:0]  pend_rd,
  output logic [REG_W-1:0]  pend_rd2
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WB_LO = 2'd1;
  localparam logic [1:0] S_WB_HI = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [1:0]        w_cap_target;
  logic [DATA_W-1:0] r_lo;
  logic [DATA_W-1:0] r_hi;
  logic [REG_W-1:0]  r_rd;
  logic [REG_W-1:0]  r_rd2;
  logic              w_cap;
  logic              w_rd2_nz;

  assign w_rd2_nz = (r_rd2 != '0);

  // A new result may enter when the port is idle or the final beat of the
  // current result leaves this cycle; flush blocks any capture.
  assign in_ready = !flush &&
                    ((r_state == S_IDLE) ||
                     ((r_state == S_WB_HI) && wb_ready) ||
                     ((r_state == S_WB_LO) && wb_ready && !w_rd2_nz));

  assign w_cap = in_valid && in_ready;

  // First beat of an incoming result; a result with both halves discarded
  // goes nowhere.
  assign w_cap_target = (in_rd  != '0) ? S_WB_LO :
                        (in_rd2 != '0) ? S_WB_HI : S_IDLE;

  // Next-state selection; flush overrides every other transition.
  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cap) w_next_state = w_cap_target;
        end
        S_WB_LO: begin
          if (wb_ready) begin
            if (w_rd2_nz)   w_next_state = S_WB_HI;
            else if (w_cap) w_next_state = w_cap_target;
            else            w_next_state = S_IDLE;
          end
        end
        S_WB_HI: begin
          if (wb_ready) w_next_state = w_cap ? w_cap_target : S_IDLE;
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Result holding registers, loaded only on an accepted result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lo  <= '0;
      r_hi  <= '0;
      r_rd  <= '0;
      r_rd2 <= '0;
    end else if (w_cap) begin
      r_lo  <= in_lo;
      r_hi  <= in_hi;
      r_rd  <= in_rd;
      r_rd2 <= in_rd2;
    end
  end

  // Writeback and scoreboard outputs decode straight from registered state,
  // so they hold steady during a stall and drop to zero on async reset.
  always_comb begin
    wb_valid   = 1'b0;
    wb_reg     = '0;
    wb_data    = '0;
    pend_valid = 1'b0;
    pend_rd    = '0;
    pend_rd2   = '0;
    case (r_state)
      S_WB_LO: begin
        wb_valid   = 1'b1;
        wb_reg     = r_rd;
        wb_data    = r_lo;
        pend_valid = 1'b1;
        pend_rd    = r_rd;
        pend_rd2   = r_rd2;
      end
      S_WB_HI: begin
        wb_valid   = 1'b1;
        wb_reg     = r_rd2;
        wb_data    = r_hi;
        pend_valid = 1'b1;
        pend_rd2   = r_rd2;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_advint_s2.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_advint_s2
// Brief    : Directed, table-driven bench for ex_advint_s2, plus a
//            hand-written asynchronous reset sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_advint_s2;

  typedef struct {
    logic        iv;
    logic [63:0] lo;
    logic [63:0] hi;
    logic [5:0]  rd;
    logic [5:0]  rd2;
    logic        wr;
    logic        fl;
    logic        e_ir;
    logic        e_wv;
    logic [5:0]  e_reg;
    logic [63:0] e_data;
    logic        e_pv;
    logic [5:0]  e_prd;
    logic [5:0]  e_prd2;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_lo = '0;
  logic [63:0] in_hi = '0;
  logic [5:0]  in_rd = '0;
  logic [5:0]  in_rd2 = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [5:0]  wb_reg;
  logic [63:0] wb_data;
  logic        pend_valid;
  logic [5:0]  pend_rd;
  logic [5:0]  pend_rd2;

  int checks = 0;
  int failures = 0;
  vec_t vq[$];

  ex_advint_s2 #(.DATA_W(64), .REG_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_lo(in_lo), .in_hi(in_hi), .in_rd(in_rd), .in_rd2(in_rd2),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_reg(wb_reg), .wb_data(wb_data),
    .pend_valid(pend_valid), .pend_rd(pend_rd), .pend_rd2(pend_rd2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " in_ready"},   64'(in_ready),   64'(v.e_ir));
    chk({tag, " wb_valid"},   64'(wb_valid),   64'(v.e_wv));
    chk({tag, " wb_reg"},     64'(wb_reg),     64'(v.e_reg));
    chk({tag, " wb_data"},    wb_data,         v.e_data);
    chk({tag, " pend_valid"}, 64'(pend_valid), 64'(v.e_pv));
    chk({tag, " pend_rd"},    64'(pend_rd),    64'(v.e_prd));
    chk({tag, " pend_rd2"},   64'(pend_rd2),   64'(v.e_prd2));
  endtask

  function automatic vec_t mk(
    input logic iv, input logic [63:0] lo, input logic [63:0] hi,
    input logic [5:0] rd, input logic [5:0] rd2, input logic wr, input logic fl,
    input logic e_ir, input logic e_wv, input logic [5:0] e_reg,
    input logic [63:0] e_data, input logic e_pv,
    input logic [5:0] e_prd, input logic [5:0] e_prd2);
    vec_t v;
    v.iv = iv; v.lo = lo; v.hi = hi; v.rd = rd; v.rd2 = rd2; v.wr = wr; v.fl = fl;
    v.e_ir = e_ir; v.e_wv = e_wv; v.e_reg = e_reg; v.e_data = e_data;
    v.e_pv = e_pv; v.e_prd = e_prd; v.e_prd2 = e_prd2;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_valid = v.iv; in_lo = v.lo; in_hi = v.hi; in_rd = v.rd; in_rd2 = v.rd2;
    wb_ready = v.wr; flush = v.fl;
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    vec_t idle_v;
    vec_t tmp;

    //          iv lo      hi      rd  rd2 wr fl | ir wv reg data    pv prd prd2
    // idle
    vq.push_back(mk(0, 0,      0,      0,  0,  1, 0,  1, 0, 0,  0,      0, 0,  0));
    // MUL: lo beat N+1, hi beat N+2, in_ready high in N+2
    vq.push_back(mk(1, 64'h1,  ONES,   5,  6,  1, 0,  1, 0, 0,  0,      0, 0,  0));
    vq.push_back(mk(0, 0,      0,      0,  0,  1, 0,  0, 1, 5,  64'h1,  1, 5,  6));
    vq.push_back(mk(0, 0,      0,      0,  0,  1, 0,  1, 1, 6,  ONES,   1, 0,  6));
    vq.push_back(mk(0, 0,      0,      0,  0,  1, 0,  1, 0, 0,  0,      0, 0,  0));
    // DIV with 3-cycle stall on the lo beat
    vq.push_back(mk(1, 64'd7,  64'd3,  10, 11, 0, 0,  1, 0, 0,  0,      0, 0,  0));
    vq.push_back(mk(0, 0,      0,      0,  0,  0, 0,  0, 1, 10, 64'd7,  1, 10, 11));
    vq.push_back(mk(0, 0,      0,      0,  0,  0, 0,  0, 1, 10, 64'd7,  1, 10, 11));
    vq.push_back(mk(0, 0,      0,      0,  0,  0, 0,  0, 1, 10, 64'd7,  1, 10, 11));
    vq.push_back(mk(0, 0,      0,      0,  0,  1, 0,  0, 1, 10, 64'd7,  1, 10, 11));
    vq.push_back(mk(0, 0,      0,      0,  0,  1, 0,  1, 1, 11, 64'd3,  1, 0,  11));
    vq.push_back(mk(0, 0,      0,      0,  0,  1, 0,  1, 0, 0,  0,      0, 0,  0));
    // rd=0: hi only; then rd=rd2=0 captured during the hi beat is dropped
    vq.push_back(mk(1, 64'hAA, 64'hBB, 0,  12, 1, 0,  1, 0, 0,  0,      0, 0,  0));
    vq.push_back(mk(1, 64'hCC, 64'hDD, 0,  0,  1, 0,  1, 1, 12, 64'hBB, 1, 0,  12));
    vq.push_back(mk(0, 0,      0,      0,  0,  1, 0,  1, 0, 0,  0,      0, 0,  0));
    vq.push_back(mk(0, 0,      0,      0,  0,  1, 0,  1, 0, 0,  0,      0, 0,  0));
    // four one-beat results back-to-back
    vq.push_back(mk(1, 64'h100, 0,     1,  0,  1, 0,  1, 0, 0,  0,      0, 0,  0));
    vq.push_back(mk(1, 64'h200, 0,     2,  0,  1, 0,  1, 1, 1,  64'h100, 1, 1, 0));
    vq.push_back(mk(1, 64'h300, 0,     3,  0,  1, 0,  1, 1, 2,  64'h200, 1, 2, 0));
    vq.push_back(mk(1, 64'h400, 0,     4,  0,  1, 0,  1, 1, 3,  64'h300, 1, 3, 0));
    vq.push_back(mk(0, 0,      0,      0,  0,  1, 0,  1, 1, 4,  64'h400, 1, 4, 0));
    vq.push_back(mk(0, 0,      0,      0,  0,  1, 0,  1, 0, 0,  0,      0, 0,  0));
    // flush during a stalled lo beat: no capture, no hi beat, pend cleared
    vq.push_back(mk(1, 64'h11, 64'h22, 7,  8,  0, 0,  1, 0, 0,  0,      0, 0,  0));
    vq.push_back(mk(1, 64'h33, 64'h44, 9,  0,  0, 1,  0, 1, 7,  64'h11, 1, 7,  8));
    vq.push_back(mk(0, 0,      0,      0,  0,  1, 0,  1, 0, 0,  0,      0, 0,  0));
    vq.push_back(mk(0, 0,      0,      0,  0,  1, 0,  1, 0, 0,  0,      0, 0,  0));
    // rd==rd2: both beats, lo then hi; next result captured during hi beat
    vq.push_back(mk(1, 64'h55, 64'h66, 9,  9,  1, 0,  1, 0, 0,  0,      0, 0,  0));
    vq.push_back(mk(0, 0,      0,      0,  0,  1, 0,  0, 1, 9,  64'h55, 1, 9,  9));
    vq.push_back(mk(1, 64'h77, 64'h88, 13, 0,  1, 0,  1, 1, 9,  64'h66, 1, 0,  9));
    vq.push_back(mk(0, 0,      0,      0,  0,  1, 0,  1, 1, 13, 64'h77, 1, 13, 0));
    vq.push_back(mk(0, 0,      0,      0,  0,  1, 0,  1, 0, 0,  0,      0, 0,  0));

    idle_v = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);

    // Power-on reset
    wb_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_all("reset", idle_v);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk); #1;
      drive(vq[i]);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vq[i]);
    end

    // Async reset in the middle of a hi beat
    @(posedge clk); #1;
    drive(mk(1, 64'hA1, 64'hB2, 20, 21, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    #2;
    chk("arst pre wb_reg", 64'(wb_reg), 64'd21);
    chk("arst pre wb_data", wb_data, 64'hB2);
    rst_n = 1'b0;
    #1;
    chk_all("arst", idle_v);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(mk(1, 64'hC3, 64'hD4, 22, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("post-arst idle wb_valid", 64'(wb_valid), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    tmp = mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 22, 64'hC3, 1, 22, 0);
    chk_all("post-arst beat", tmp);
    @(posedge clk); #1;
    @(negedge clk);
    chk_all("post-arst idle", idle_v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
